fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, issues instruction-memory requests over a req/ready handshake, and loads the IF/ID pipeline register. Sits directly upstream of the branch/next-PC logic: it exports `PcP4` to that logic and takes back the selected `NextPc`. It also takes that logic's taken-branch indication, `Redirect`, as a flush.

---
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and instruction memory.
// The fetch stage drives the request side; memory answers with ready and read data.
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemRdata;

  modport master (output ImemReq, ImemAddr, input ImemReady, ImemRdata);
  modport slave  (input ImemReq, ImemAddr, output ImemReady, ImemRdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem req/ready handshake, one-entry skid buffer, IF/ID register.
// Optional bubble counter output BubbleCnt is enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master imem,
  input  logic [31:0]   NextPc,
  input  logic          Redirect,
  input  logic          Stall,
  output logic [31:0]   PcP4,
  output logic [31:0]   IfIdInstr,
  output logic [31:0]   IfIdPcP4,
  output logic          IfIdValid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   BubbleCnt
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_p4_q, skid_pc_p4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_p4_q, ifid_pc_p4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        load_bubble;

  assign PcP4          = pc_q + 32'd4;
  assign imem.ImemAddr = req_addr_q;
  assign imem.ImemReq  = rst_n && (state_q != HELD);
  assign IfIdInstr     = ifid_instr_q;
  assign IfIdPcP4      = ifid_pc_p4_q;
  assign IfIdValid     = ifid_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_p4_d = skid_pc_p4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_p4_d = ifid_pc_p4_q;
    ifid_valid_d = ifid_valid_q;
    load_bubble  = 1'b0;

    case (state_q)
      FETCH: begin
        if (Redirect) begin
          ifid_valid_d = 1'b0;
          load_bubble  = 1'b1;
          pc_d         = NextPc;
          // An unanswered request cannot be withdrawn, so its answer must be drained first.
          if (imem.ImemReady) req_addr_d = NextPc;
          else                state_d    = DRAIN;
        end else if (imem.ImemReady && !Stall) begin
          ifid_instr_d = imem.ImemRdata;
          ifid_pc_p4_d = PcP4;
          ifid_valid_d = 1'b1;
          pc_d         = NextPc;
          req_addr_d   = NextPc;
        end else if (imem.ImemReady) begin
          skid_instr_d = imem.ImemRdata;
          skid_pc_p4_d = PcP4;
          state_d      = HELD;
        end else if (!Stall) begin
          ifid_valid_d = 1'b0;
          load_bubble  = 1'b1;
        end
      end

      HELD: begin
        if (Redirect) begin
          ifid_valid_d = 1'b0;
          load_bubble  = 1'b1;
          pc_d         = NextPc;
          req_addr_d   = NextPc;
          state_d      = FETCH;
        end else if (!Stall) begin
          ifid_instr_d = skid_instr_q;
          ifid_pc_p4_d = skid_pc_p4_q;
          ifid_valid_d = 1'b1;
          pc_d         = NextPc;
          req_addr_d   = NextPc;
          state_d      = FETCH;
        end
      end

      DRAIN: begin
        ifid_valid_d = 1'b0;
        load_bubble  = 1'b1;
        if (Redirect) pc_d = NextPc;
        // Restart from the newest target, including one arriving this very cycle.
        if (imem.ImemReady) begin
          req_addr_d = pc_d;
          state_d    = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc_p4_q <= '0;
      ifid_instr_q <= '0;
      ifid_pc_p4_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_p4_q <= skid_pc_p4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_p4_q <= ifid_pc_p4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (load_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign BubbleCnt = bubble_cnt_q;
`else
  logic unused_load_bubble;
  assign unused_load_bubble = load_bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed cycles push expected fetch addresses and IF/ID loads,
// a negedge monitor pops them as the DUT handshakes with memory or loads a new IF/ID word.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] NextPc;
  logic        Redirect;
  logic        Stall;
  logic [31:0] PcP4;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPcP4;
  logic        IfIdValid;
  logic [31:0] redirectTarget;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] BubbleCnt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] addrQ[$];
  logic [63:0] ifIdQ[$];

  fetch_stage_if imemBus ();

  fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem      (imemBus.master),
    .NextPc    (NextPc),
    .Redirect  (Redirect),
    .Stall     (Stall),
    .PcP4      (PcP4),
    .IfIdInstr (IfIdInstr),
    .IfIdPcP4  (IfIdPcP4),
    .IfIdValid (IfIdValid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .BubbleCnt (BubbleCnt)
`endif
  );

  // Branch logic model: sequential unless redirected. Memory returns a word tagged with its address.
  assign NextPc            = Redirect ? redirectTarget : PcP4;
  assign imemBus.ImemRdata = {8'hC0, imemBus.ImemAddr[23:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic stall, input logic redir, input logic [31:0] tgt);
    imemBus.ImemReady = ready;
    Stall             = stall;
    Redirect          = redir;
    redirectTarget    = tgt;
    @(posedge clk);
    #1;
  endtask

  function automatic void expectFetch(input logic [31:0] addr);
    addrQ.push_back(addr);
  endfunction

  function automatic void expectLoad(input logic [31:0] instr, input logic [31:0] pcP4);
    ifIdQ.push_back({instr, pcP4});
  endfunction

  // Monitor: a handshake consumes one expected address; a freshly loaded valid IF/ID word consumes one load.
  logic        prevValid = 1'b0;
  logic [63:0] prevWord  = '0;
  logic [63:0] expWord;
  logic [31:0] expAddr;

  always @(negedge clk) begin
    if (imemBus.ImemReq && imemBus.ImemReady) begin
      checkCount++;
      if (addrQ.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL fetchAddr: unexpected fetch of %h, expected none", imemBus.ImemAddr);
      end else begin
        expAddr = addrQ.pop_front();
        if (imemBus.ImemAddr !== expAddr) begin
          errorCount++;
          $display("[TB] FAIL fetchAddr: got %h, expected %h", imemBus.ImemAddr, expAddr);
        end
      end
    end
    if (IfIdValid && (!prevValid || {IfIdInstr, IfIdPcP4} != prevWord)) begin
      checkCount++;
      if (ifIdQ.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL ifIdLoad: unexpected load %h/%h, expected none", IfIdInstr, IfIdPcP4);
      end else begin
        expWord = ifIdQ.pop_front();
        if ({IfIdInstr, IfIdPcP4} !== expWord) begin
          errorCount++;
          $display("[TB] FAIL ifIdLoad: got %h/%h, expected %h/%h",
                   IfIdInstr, IfIdPcP4, expWord[63:32], expWord[31:0]);
        end
      end
    end
    prevValid = IfIdValid;
    prevWord  = {IfIdInstr, IfIdPcP4};
  end

  initial begin
    rst_n             = 1'b0;
    imemBus.ImemReady = 1'b1;
    Stall             = 1'b0;
    Redirect          = 1'b0;
    redirectTarget    = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("resetReq", {31'd0, imemBus.ImemReq}, 32'd0);
    checkOutput("resetValid", {31'd0, IfIdValid}, 32'd0);
    checkOutput("resetInstr", IfIdInstr, 32'h0);
    checkOutput("resetPcP4Reg", IfIdPcP4, 32'h0);
    checkOutput("resetAddr", imemBus.ImemAddr, 32'h0040_0000);
    checkOutput("resetPcP4", PcP4, 32'h0040_0004);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("resetBubbleCnt", BubbleCnt, 32'd0);
`endif

    // Zero-wait sequential fetch
    expectFetch(32'h0040_0000); expectLoad(32'hC040_0000, 32'h0040_0004);
    expectFetch(32'h0040_0004); expectLoad(32'hC040_0004, 32'h0040_0008);
    expectFetch(32'h0040_0008); expectLoad(32'hC040_0008, 32'h0040_000C);
    rst_n = 1'b1;
    #1;
    checkOutput("reqAfterRelease", {31'd0, imemBus.ImemReq}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("firstIfIdPcP4", IfIdPcP4, 32'h0040_0004);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // Three-cycle stall on a ready fetch: word goes to skid, request drops in HELD
    expectFetch(32'h0040_000C);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("heldReq1", {31'd0, imemBus.ImemReq}, 32'd0);
    checkOutput("heldInstr", IfIdInstr, 32'hC040_0008);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("heldReq2", {31'd0, imemBus.ImemReq}, 32'd0);
    checkOutput("heldPcP4", IfIdPcP4, 32'h0040_000C);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("heldReq3", {31'd0, imemBus.ImemReq}, 32'd0);
    expectLoad(32'hC040_000C, 32'h0040_0010);
    expectFetch(32'h0040_0010);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("skidValid", {31'd0, IfIdValid}, 32'd1);
    checkOutput("afterSkidAddr", imemBus.ImemAddr, 32'h0040_0010);
    expectLoad(32'hC040_0010, 32'h0040_0014);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect overrides stall while IF/ID holds a valid word
    expectFetch(32'h0040_0014);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0040_0100);
    checkOutput("redirFlush", {31'd0, IfIdValid}, 32'd0);
    checkOutput("redirAddr", imemBus.ImemAddr, 32'h0040_0100);
    expectFetch(32'h0040_0100); expectLoad(32'hC040_0100, 32'h0040_0104);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // Two wait states with a redirect in the first one: old request drains, data dropped
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0200);
    checkOutput("drainAddr1", imemBus.ImemAddr, 32'h0040_0104);
    checkOutput("drainReq", {31'd0, imemBus.ImemReq}, 32'd1);
    checkOutput("drainValid", {31'd0, IfIdValid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("drainAddr2", imemBus.ImemAddr, 32'h0040_0104);
    expectFetch(32'h0040_0104);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("postDrainAddr", imemBus.ImemAddr, 32'h0040_0200);
    checkOutput("postDrainValid", {31'd0, IfIdValid}, 32'd0);
    expectFetch(32'h0040_0200); expectLoad(32'hC040_0200, 32'h0040_0204);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // Memory not ready without stall inserts a bubble and holds the address
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("bubbleValid", {31'd0, IfIdValid}, 32'd0);
    checkOutput("bubbleAddr", imemBus.ImemAddr, 32'h0040_0204);
    expectFetch(32'h0040_0204); expectLoad(32'hC040_0204, 32'h0040_0208);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // PC wrap-around at the top of the address space
    expectFetch(32'h0040_0208);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrapPcP4", PcP4, 32'h0000_0000);
    checkOutput("wrapAddr", imemBus.ImemAddr, 32'hFFFF_FFFC);
    expectFetch(32'hFFFF_FFFC); expectLoad(32'hC0FF_FFFC, 32'h0000_0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("afterWrapPcP4", PcP4, 32'h0000_0004);

    // Reset asserted in the middle of a drain
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0300);
    checkOutput("preResetDrainAddr", imemBus.ImemAddr, 32'h0000_0000);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetReq", {31'd0, imemBus.ImemReq}, 32'd0);
    checkOutput("midResetValid", {31'd0, IfIdValid}, 32'd0);
    checkOutput("midResetInstr", IfIdInstr, 32'h0);
    checkOutput("midResetPcP4Reg", IfIdPcP4, 32'h0);
    checkOutput("midResetAddr", imemBus.ImemAddr, 32'h0040_0000);
    imemBus.ImemReady = 1'b1;
    Redirect          = 1'b0;
    Stall             = 1'b0;
    expectFetch(32'h0040_0000); expectLoad(32'hC040_0000, 32'h0040_0004);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("restartHoldValid", {31'd0, IfIdValid}, 32'd1);

    // Two wait-state cycles after the restart produce two bubbles
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("waitBubbleValid", {31'd0, IfIdValid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("bubbleCnt", BubbleCnt, 32'd2);
`endif

    checkOutput("addrQueueDrained", addrQ.size(), 32'd0);
    checkOutput("ifIdQueueDrained", ifIdQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
